// File: rtl/base64_pkg.sv
`default_nettype none
// ============================================================================
// Module      : base64_pkg
// Description : Shared types, constants and the sextet-to-ASCII mapping for
//               the Base64 stream encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package base64_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    EMIT    = 2'd1,
    NEWLINE = 2'd2
  } b64_state_t;

  localparam logic [7:0] PAD_CHAR = 8'h3D;
  localparam logic [7:0] NL_CHAR  = 8'h0A;

  // Map a 6-bit index onto its Base64 character; url_safe only changes 62/63.
  function automatic logic [7:0] b64_char(input logic [5:0] idx, input logic url_safe);
    logic [7:0] c;
    if (idx < 6'd26) begin
      c = 8'h41 + {2'b00, idx};
    end else if (idx < 6'd52) begin
      c = 8'h61 + {2'b00, idx - 6'd26};
    end else if (idx < 6'd62) begin
      c = 8'h30 + {2'b00, idx - 6'd52};
    end else if (idx == 6'd62) begin
      c = url_safe ? 8'h2D : 8'h2B;
    end else begin
      c = url_safe ? 8'h5F : 8'h2F;
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/base64_sextet_to_ascii.sv
`default_nettype none
// ============================================================================
// Module      : base64_sextet_to_ascii
// Description : Combinational 6-bit index to ASCII Base64 character lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module base64_sextet_to_ascii #(
  parameter bit URL_SAFE = 1'b0
) (
  input  logic [5:0] sextet,
  output logic [7:0] ascii
);
  import base64_pkg::*;

  // Pure table lookup, alphabet fixed at elaboration.
  assign ascii = b64_char(sextet, URL_SAFE);

endmodule
`default_nettype wire

// File: rtl/base64_stream_encoder.sv
`default_nettype none
// ============================================================================
// Module      : base64_stream_encoder
// Description : Byte stream in, Base64 ASCII characters out, with optional
//               URL-safe alphabet, '=' padding and fixed-length line wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module base64_stream_encoder #(
  parameter bit URL_SAFE = 1'b0,
  parameter bit PAD_EN   = 1'b1,
  parameter int LINE_LEN = 0
) (
  input  logic       ctrl,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_char,
  output logic       out_last
);
  import base64_pkg::*;

  localparam int LCNT_W = (LINE_LEN > 0) ? $clog2(LINE_LEN + 1) : 1;

  b64_state_t        state, state_d;
  logic [23:0]       grp, grp_d;
  logic [1:0]        nb, nb_d;
  logic [1:0]        cidx, cidx_d;
  logic [LCNT_W-1:0] lcnt, lcnt_d;
  logic [LCNT_W-1:0] lcnt_inc;
  logic              last_grp, last_grp_d;
  logic [5:0]        sextet;
  logic [7:0]        data_char;
  logic [1:0]        final_idx;
  logic              is_final;
  logic              wrap_hit;

  // Pick the sextet addressed by the current character index.
  always_comb begin
    case (cidx)
      2'd0:    sextet = grp[23:18];
      2'd1:    sextet = grp[17:12];
      2'd2:    sextet = grp[11:6];
      default: sextet = grp[5:0];
    endcase
  end

  base64_sextet_to_ascii #(
    .URL_SAFE(URL_SAFE)
  ) u_lut (
    .sextet(sextet),
    .ascii (data_char)
  );

  // With padding every group is 4 characters; without it, nb+1 characters.
  assign final_idx = PAD_EN ? 2'd3 : nb;
  assign is_final  = (cidx == final_idx);
  assign lcnt_inc  = lcnt + 1'b1;

  // Wrap check only exists when wrapping is enabled; >= covers unpadded groups.
  generate
    if (LINE_LEN != 0) begin : g_wrap_on
      assign wrap_hit = ({{(32-LCNT_W){1'b0}}, lcnt_inc} >= 32'(LINE_LEN));
    end else begin : g_wrap_off
      assign wrap_hit = 1'b0;
    end
  endgenerate

  // Outputs decoded from state registers only (no input-to-output path).
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_char  = 8'h00;
    out_last  = 1'b0;
    case (state)
      COLLECT: in_ready = 1'b1;
      EMIT: begin
        out_valid = 1'b1;
        out_char  = (cidx > nb) ? PAD_CHAR : data_char;
        out_last  = last_grp & is_final;
      end
      NEWLINE: begin
        out_valid = 1'b1;
        out_char  = NL_CHAR;
      end
      default: ;
    endcase
  end

  // Next-state logic for the FSM, group register and counters.
  always_comb begin
    state_d    = state;
    grp_d      = grp;
    nb_d       = nb;
    cidx_d     = cidx;
    lcnt_d     = lcnt;
    last_grp_d = last_grp;
    case (state)
      COLLECT: begin
        if (in_valid && in_ready) begin
          case (nb)
            2'd0:    grp_d[23:16] = in_data;
            2'd1:    grp_d[15:8]  = in_data;
            default: grp_d[7:0]   = in_data;
          endcase
          nb_d = nb + 2'd1;
          if (nb == 2'd2 || in_last) begin
            state_d    = EMIT;
            cidx_d     = 2'd0;
            last_grp_d = in_last;
          end
        end
      end
      EMIT: begin
        if (out_valid && out_ready) begin
          cidx_d = cidx + 2'd1;
          lcnt_d = lcnt_inc;
          if (is_final) begin
            cidx_d = 2'd0;
            if (last_grp) begin
              lcnt_d     = '0;
              last_grp_d = 1'b0;
              nb_d       = 2'd0;
              grp_d      = '0;
              state_d    = COLLECT;
            end else if (wrap_hit) begin
              state_d = NEWLINE;
            end else begin
              nb_d    = 2'd0;
              grp_d   = '0;
              state_d = COLLECT;
            end
          end
        end
      end
      NEWLINE: begin
        if (out_valid && out_ready) begin
          lcnt_d  = '0;
          nb_d    = 2'd0;
          grp_d   = '0;
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // State register; reset discards any partial group.
  always_ff @(posedge ctrl or negedge rst) begin
    if (!rst) begin
      state    <= COLLECT;
      grp      <= '0;
      nb       <= 2'd0;
      cidx     <= 2'd0;
      lcnt     <= '0;
      last_grp <= 1'b0;
    end else begin
      state    <= state_d;
      grp      <= grp_d;
      nb       <= nb_d;
      cidx     <= cidx_d;
      lcnt     <= lcnt_d;
      last_grp <= last_grp_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_base64_stream_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_base64_stream_encoder
// Description : Directed self-checking bench for base64_stream_encoder with
//               four parameter variants (standard, URL-safe, unpadded, wrap).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_base64_stream_encoder;

  logic       clk;
  logic       rst_n;
  logic       in_valid  [4];
  logic [7:0] in_data   [4];
  logic       in_last   [4];
  logic       out_ready [4];
  logic       in_ready  [4];
  logic       out_valid [4];
  logic [7:0] out_char  [4];
  logic       out_last  [4];

  int checks = 0;
  int errors = 0;

  localparam int D_STD  = 0;
  localparam int D_URL  = 1;
  localparam int D_NPAD = 2;
  localparam int D_WRAP = 3;

  base64_stream_encoder #(.URL_SAFE(1'b0), .PAD_EN(1'b1), .LINE_LEN(0)) u_std (
    .ctrl(clk), .rst(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_last(in_last[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_char(out_char[0]), .out_last(out_last[0])
  );

  base64_stream_encoder #(.URL_SAFE(1'b1), .PAD_EN(1'b1), .LINE_LEN(0)) u_url (
    .ctrl(clk), .rst(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_last(in_last[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_char(out_char[1]), .out_last(out_last[1])
  );

  base64_stream_encoder #(.URL_SAFE(1'b0), .PAD_EN(1'b0), .LINE_LEN(0)) u_npad (
    .ctrl(clk), .rst(rst_n),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]), .in_last(in_last[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_char(out_char[2]), .out_last(out_last[2])
  );

  base64_stream_encoder #(.URL_SAFE(1'b0), .PAD_EN(1'b1), .LINE_LEN(4)) u_wrap (
    .ctrl(clk), .rst(rst_n),
    .in_valid(in_valid[3]), .in_ready(in_ready[3]), .in_data(in_data[3]), .in_last(in_last[3]),
    .out_valid(out_valid[3]), .out_ready(out_ready[3]), .out_char(out_char[3]), .out_last(out_last[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer one byte from the falling edge and hold it until accepted.
  task automatic push_byte(input int d, input logic [7:0] b, input logic last);
    int t;
    t = 0;
    @(negedge clk);
    in_valid[d] = 1'b1;
    in_data[d]  = b;
    in_last[d]  = last;
    while (!in_ready[d] && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("in_ready_wait", {31'd0, in_ready[d]}, 32'd1);
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
    in_last[d]  = 1'b0;
  endtask

  task automatic push_msg(input int d, input string msg, input bit with_last);
    for (int i = 0; i < msg.len(); i++) begin
      push_byte(d, msg[i], with_last && (i == msg.len() - 1));
    end
  endtask

  // Drain exp.len() characters, checking each and its out_last flag.
  task automatic expect_chars(input int d, input string exp, input string tag, input bit has_last);
    int t;
    for (int i = 0; i < exp.len(); i++) begin
      t = 0;
      @(negedge clk);
      while (!out_valid[d] && t < 20) begin
        @(negedge clk);
        t++;
      end
      check($sformatf("%s_valid%0d", tag, i), {31'd0, out_valid[d]}, 32'd1);
      check($sformatf("%s_char%0d", tag, i), {24'd0, out_char[d]}, {24'd0, exp[i]});
      check($sformatf("%s_last%0d", tag, i), {31'd0, out_last[d]},
            {31'd0, (has_last && (i == exp.len() - 1))});
      out_ready[d] = 1'b1;
      @(posedge clk);
      #1;
      out_ready[d] = 1'b0;
    end
  endtask

  task automatic expect_idle(input int d, input string tag);
    @(negedge clk);
    check({tag, "_idle_valid"}, {31'd0, out_valid[d]}, 32'd0);
    check({tag, "_idle_ready"}, {31'd0, in_ready[d]}, 32'd1);
  endtask

  // Directed test sequence.
  initial begin
    for (int k = 0; k < 4; k++) begin
      in_valid[k]  = 1'b0;
      in_data[k]   = 8'h00;
      in_last[k]   = 1'b0;
      out_ready[k] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready[0]}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid[0]}, 32'd0);
    check("rst_out_char", {24'd0, out_char[0]}, 32'd0);
    check("rst_out_last", {31'd0, out_last[0]}, 32'd0);
    rst_n = 1'b1;

    // "Man": latency and full group.
    push_msg(D_STD, "Man", 1'b1);
    check("man_latency_valid", {31'd0, out_valid[0]}, 32'd1);
    check("man_latency_in_ready", {31'd0, in_ready[0]}, 32'd0);
    expect_chars(D_STD, "TWFu", "man", 1'b1);
    expect_idle(D_STD, "man");

    // Padded partial groups.
    push_msg(D_STD, "Ma", 1'b1);
    expect_chars(D_STD, "TWE=", "ma", 1'b1);
    push_msg(D_STD, "M", 1'b1);
    expect_chars(D_STD, "TQ==", "m", 1'b1);

    // Unpadded single byte.
    push_msg(D_NPAD, "M", 1'b1);
    expect_chars(D_NPAD, "TQ", "npad", 1'b1);
    expect_idle(D_NPAD, "npad");

    // Indices 62/63 in both alphabets.
    push_byte(D_STD, 8'hFB, 1'b0);
    push_byte(D_STD, 8'hFF, 1'b0);
    push_byte(D_STD, 8'hBF, 1'b1);
    expect_chars(D_STD, "+/+/", "std6263", 1'b1);
    push_byte(D_URL, 8'hFB, 1'b0);
    push_byte(D_URL, 8'hFF, 1'b0);
    push_byte(D_URL, 8'hBF, 1'b1);
    expect_chars(D_URL, "-_-_", "url6263", 1'b1);

    // Line wrapping at 4 characters, twice to confirm the line counter restarts.
    for (int r = 0; r < 2; r++) begin
      push_msg(D_WRAP, "Man", 1'b0);
      expect_chars(D_WRAP, "TWFu\n", $sformatf("wrap%0d_a", r), 1'b0);
      push_msg(D_WRAP, "Man", 1'b1);
      expect_chars(D_WRAP, "TWFu", $sformatf("wrap%0d_b", r), 1'b1);
      expect_idle(D_WRAP, $sformatf("wrap%0d", r));
      check($sformatf("wrap%0d_lcnt", r), 32'(u_wrap.lcnt), 32'd0);
    end

    // Sink stall mid-group.
    push_msg(D_STD, "Man", 1'b1);
    expect_chars(D_STD, "T", "stall_a", 1'b0);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      check($sformatf("stall%0d_valid", s), {31'd0, out_valid[0]}, 32'd1);
      check($sformatf("stall%0d_char", s), {24'd0, out_char[0]}, 32'h57);
      check($sformatf("stall%0d_last", s), {31'd0, out_last[0]}, 32'd0);
      check($sformatf("stall%0d_in_ready", s), {31'd0, in_ready[0]}, 32'd0);
    end
    expect_chars(D_STD, "WFu", "stall_b", 1'b1);

    // Asynchronous reset in the middle of emission.
    push_msg(D_STD, "Man", 1'b1);
    expect_chars(D_STD, "TW", "rstmid", 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid_out_valid", {31'd0, out_valid[0]}, 32'd0);
    check("rstmid_in_ready", {31'd0, in_ready[0]}, 32'd1);
    check("rstmid_out_char", {24'd0, out_char[0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push_msg(D_STD, "Ma", 1'b1);
    expect_chars(D_STD, "TWE=", "rstpost", 1'b1);
    expect_idle(D_STD, "rstpost");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/base64_stream_encoder.md
# base64_stream_encoder

Synthesizable, parametrised Base64 encoder that replaces print-only, simulation-side sextet decoding in the Base64 output path. It accepts a byte stream over a valid/ready handshake and emits the ASCII Base64 characters over a second valid/ready handshake. Options cover the standard or URL-safe alphabet, optional `=` padding and optional fixed-length line wrapping. It sits between the byte source and any character sink (UART TX, text FIFO, bench monitor).

## Interface
- `URL_SAFE`, 0: selects the alphabet for indices 62/63.
  - 0: `+` (0x2B) and `/` (0x2F).
  - 1: `-` (0x2D) and `_` (0x5F).
- `PAD_EN`, 1: 1 emits `=` padding to a 4-character multiple; 0 emits no padding.
- `LINE_LEN`, 0: 0 disables wrapping; otherwise insert `\n` (0x0A) after every `LINE_LEN` emitted characters. Must be a multiple of 4; legal range 4..252.

Ports:
- `ctrl` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: input byte valid.
- `in_ready` out 1: encoder can accept a byte.
- `in_data` in 8: input byte.
- `in_last` in 1: qualifies the final byte of a message.
- `out_valid` out 1: output character valid.
- `out_ready` in 1: sink accepts the character.
- `out_char` out 8: ASCII character.
- `out_last` out 1: set on the final character of a message.

## Operation
- Group register: 24 bits, `{b0,b1,b2}`, with `b0` in bits 23:16. Missing bytes read as 0.
  - Sextet k = `group[23-6k -: 6]`.
  - Index mapping: 0–25 → `A`–`Z`, 26–51 → `a`–`z`, 52–61 → `0`–`9`, 62/63 per `URL_SAFE`.
- Byte count `nb` is 1..3. Data characters per group = `nb+1`.
  - `PAD_EN=1`: add `3-nb` `=` (0x3D) characters, giving 4 characters total.
  - `PAD_EN=0`: no padding characters.
- FSM states: `COLLECT`, `EMIT`, `NEWLINE`.
  - `COLLECT`:
    - `in_ready=1`, `out_valid=0`.
    - On accept (`in_valid & in_ready`), store the byte at slot `nb` and increment `nb`.
    - If the byte is slot 2 or `in_last`=1: go to `EMIT`, `cidx=0`, latch `last_grp=in_last`.
  - `EMIT`:
    - `in_ready=0`, `out_valid=1`, `out_char` = character `cidx` of the group.
    - On accept (`out_valid & out_ready`), increment `cidx` and the line counter `lcnt`.
    - After the group's final character:
      - If `last_grp`: clear `lcnt`, go to `COLLECT`, clear `nb`.
      - Else if `LINE_LEN!=0` and `lcnt` reached `LINE_LEN`: go to `NEWLINE`.
      - Else: go to `COLLECT`, clear `nb`.
  - `NEWLINE`:
    - `out_valid=1`, `out_char=0x0A`, `out_last=0`.
    - On accept: clear `lcnt`, clear `nb`, go to `COLLECT`.
- `out_last` = `last_grp` AND the current character is the group's final character. No newline ever follows `out_last`.
- `in_last` applies only to an accepted byte. An empty message is not representable.
- Because `LINE_LEN` is a multiple of 4, `lcnt` reaches `LINE_LEN` only at a group boundary (requires `PAD_EN=1`). With `PAD_EN=0`, wrapping still triggers at the first group end where `lcnt >= LINE_LEN`.
- Reset (any time, including mid-`EMIT`/`NEWLINE`):
  - Partial group discarded; state `COLLECT`.
  - `nb=0`, `cidx=0`, `lcnt=0`, `last_grp=0`.
  - Outputs: `in_ready=1`, `out_valid=0`, `out_char=0x00`, `out_last=0`.

## Timing
- All state is registered on `ctrl` rising edge. Outputs are decoded from registers only; there is no combinational path from `in_*`/`out_ready` to any output.
- Latency: the accept edge of the group-closing byte is followed directly by `out_valid=1` in the next cycle.
- Throughput, full groups, no stalls: 3 cycles in + 4 cycles out per group, non-overlapped, plus 1 cycle per newline.
- While `out_valid=1` and `out_ready=0`, `out_char` and `out_last` hold stable. `out_valid` never drops without a handshake.
- `in_ready` is low throughout `EMIT`/`NEWLINE`. A source holding `in_valid` high simply waits.
- `lcnt` width: `$clog2(LINE_LEN+1)`, minimum 1 bit.

## Structure
- Package `base64_pkg`:
  - State enum `b64_state_t` (`COLLECT`, `EMIT`, `NEWLINE`).
  - Constants `PAD_CHAR` = 8'h3D and `NL_CHAR` = 8'h0A.
  - Function `b64_char(idx, url_safe)` returning ASCII.
- One sub-module, `base64_sextet_to_ascii`: combinational 6→8 lookup with parameter `URL_SAFE`. It is instantiated once and fed the sextet selected by `cidx`.
- Top module holds the FSM, group register, counters and pad/newline muxing.

## Test plan
- Bytes "Man" (0x4D 0x61 0x6E, last on 0x6E) → `TWFu`; `out_last` on `u`; first `out_valid` one cycle after third accept.
- "Ma"+last → `TWE=`; "M"+last → `TQ==`. With `PAD_EN=0`, "M"+last → `TQ` with `out_last` on `Q`.
- Bytes 0xFB 0xFF 0xBF: `URL_SAFE=0` → `+/+/`; `URL_SAFE=1` → `-_-_`.
- `LINE_LEN=4`, "ManMan"+last → `TWFu`, 0x0A, `TWFu`; `out_last` on final `u`; no trailing newline; `lcnt` is 0 afterwards.
- Hold `out_ready=0` for 5 cycles mid-group: `out_char`/`out_last` stable, `in_ready=0`, no character lost or duplicated.
- Assert `rst` low during `EMIT` of "Man" after 2 characters:
  - Immediately: `out_valid=0`, `in_ready=1`.
  - After release, "Ma"+last → `TWE=` exactly.
